mem_arbiter: RTL and testbench

Two-port arbiter and response router in front of the single-port, 16-entry, 32-bit synchronous-read instruction/data ROM. It shares the ROM between the instruction-fetch requester (IF) and the data-read requester (DM). Conflicts are resolved round-robin. Read data returns one cycle after grant, and each port has its own valid/ready response channel with a one-entry hold register.

---
 rtl/mem_arbiter.sv | 108 ++++++++++
 tb/tb_mem_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin two-port arbiter in front of a synchronous-read ROM with a
// per-port valid/ready response channel and one-entry hold register.

module mem_arbiter_port #(
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              gnt,
  input  logic              rsp_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              eligible
);
  logic              inflight, hold;
  logic [DATA_W-1:0] hold_data;

  assign rsp_valid = inflight | hold;
  assign rsp_data  = hold ? hold_data : mem_rdata;
  assign eligible  = !rsp_valid | rsp_ready;

  // ROM output lasts only one cycle, so a refused response is parked in hold.
  always_ff @(posedge CLK) begin
    if (RST) begin
      inflight  <= 1'b0;
      hold      <= 1'b0;
      hold_data <= '0;
    end else begin
      inflight <= gnt;
      if (inflight && !rsp_ready) begin
        hold      <= 1'b1;
        hold_data <= mem_rdata;
      end else if (hold && rsp_ready) begin
        hold <= 1'b0;
      end
    end
  end
endmodule

module mem_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              if_rsp_ready,
  input  logic              dm_req,
  input  logic [ADDR_W-1:0] dm_addr,
  output logic              dm_gnt,
  output logic              dm_rsp_valid,
  output logic [DATA_W-1:0] dm_rsp_data,
  input  logic              dm_rsp_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int NUM_PORTS = 2;  // index 0 = IF, 1 = DM

  logic [NUM_PORTS-1:0]             req, rdy, gnt, vld, elig, cand;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rdat;
  logic                             last_gnt;  // 1 = DM granted last

  assign req  = {dm_req, if_req};
  assign rdy  = {dm_rsp_ready, if_rsp_ready};
  assign cand = req & elig;

  always_comb begin
    gnt = '0;
    if (!RST) begin
      if (&cand) gnt = last_gnt ? 2'b01 : 2'b10;
      else       gnt = cand;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)       last_gnt <= 1'b1;
    else if (|gnt) last_gnt <= gnt[1];
  end

  assign mem_addr = gnt[1] ? dm_addr : if_addr;

  generate
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      mem_arbiter_port #(.DATA_W(DATA_W)) u_port (
        .CLK       (CLK),
        .RST       (RST),
        .gnt       (gnt[p]),
        .rsp_ready (rdy[p]),
        .mem_rdata (mem_rdata),
        .rsp_valid (vld[p]),
        .rsp_data  (rdat[p]),
        .eligible  (elig[p])
      );
    end
  endgenerate

  assign if_gnt       = gnt[0];
  assign dm_gnt       = gnt[1];
  assign if_rsp_valid = vld[0];
  assign dm_rsp_valid = vld[1];
  assign if_rsp_data  = rdat[0];
  assign dm_rsp_data  = rdat[1];
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a bench ROM and a
// valid/data-level reference model of each response channel.

module tb_mem_arbiter;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [1:0]  req = '0, rdy = '0;
  logic [3:0]  addr [2];
  logic        if_gnt, dm_gnt, if_rsp_valid, dm_rsp_valid;
  logic [31:0] if_rsp_data, dm_rsp_data, mem_rdata;
  logic [3:0]  mem_addr;
  logic [31:0] rom [16];
  int          total = 0, bad = 0;

  logic [1:0]  mv, eg, el, cand;
  logic [31:0] md [2];
  logic        mlast;

  always #5 CLK = ~CLK;
  always @(posedge CLK) mem_rdata <= rom[mem_addr];

  mem_arbiter #(.ADDR_W(4), .DATA_W(32)) u_dut (
    .CLK(CLK), .RST(RST),
    .if_req(req[0]), .if_addr(addr[0]), .if_gnt(if_gnt),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_ready(rdy[0]),
    .dm_req(req[1]), .dm_addr(addr[1]), .dm_gnt(dm_gnt),
    .dm_rsp_valid(dm_rsp_valid), .dm_rsp_data(dm_rsp_data), .dm_rsp_ready(rdy[1]),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK); #1;
  endtask

  task automatic do_rst(input int n);
    RST = 1'b1;
    repeat (n) begin
      @(negedge CLK);
      chk("rst_gnt", {30'd0, dm_gnt, if_gnt}, 32'd0);
      cyc();
    end
    RST = 1'b0;
  endtask

  initial begin
    logic [31:0] t2 [3];
    for (int i = 0; i < 16; i++) rom[i] = 32'h1000_0000 + i * 32'h111;
    rom[0] = 32'h002180B3; rom[1] = 32'h002080B3; rom[2] = 32'h00000003;
    rom[7] = 32'h00000007; rom[8] = 32'h0000000F;
    t2[0] = 32'h002180B3; t2[1] = 32'h002080B3; t2[2] = 32'h00000003;
    addr[0] = '0; addr[1] = '0;

    // 1: reset state, single IF read
    do_rst(2);
    @(negedge CLK);
    chk("t1_ivld", if_rsp_valid, 0); chk("t1_dvld", dm_rsp_valid, 0);
    chk("t1_gnt", {dm_gnt, if_gnt}, 0);
    cyc(); req[0] = 1; addr[0] = 0; rdy = 2'b11;
    @(negedge CLK);
    chk("t1_ignt", if_gnt, 1); chk("t1_dgnt", dm_gnt, 0);
    cyc(); req[0] = 0;
    @(negedge CLK);
    chk("t1_ivld2", if_rsp_valid, 1); chk("t1_idat", if_rsp_data, 32'h002180B3);
    chk("t1_dvld2", dm_rsp_valid, 0); chk("t1_ignt2", if_gnt, 0);

    // 2: IF streaming back-to-back
    cyc();
    for (int i = 0; i < 4; i++) begin
      req[0] = (i < 3); addr[0] = 4'(i);
      @(negedge CLK);
      chk("t2_ignt", if_gnt, (i < 3) ? 1 : 0);
      if (i > 0) begin
        chk("t2_ivld", if_rsp_valid, 1); chk("t2_idat", if_rsp_data, t2[i-1]);
      end
      cyc();
    end
    @(negedge CLK); chk("t2_ivld_end", if_rsp_valid, 0);

    // 3: continuous conflict, IF wins first after reset, then alternate
    cyc(); req = 2'b11; addr[0] = 7; addr[1] = 8;
    do_rst(2);
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      chk("t3_ignt", if_gnt, (k % 2 == 0) ? 1 : 0);
      chk("t3_dgnt", dm_gnt, (k % 2 == 1) ? 1 : 0);
      if (k > 0) begin
        chk("t3_ivld", if_rsp_valid, ((k - 1) % 2 == 0) ? 1 : 0);
        chk("t3_dvld", dm_rsp_valid, ((k - 1) % 2 == 1) ? 1 : 0);
        if ((k - 1) % 2 == 0) chk("t3_idat", if_rsp_data, 32'h7);
        else                  chk("t3_ddat", dm_rsp_data, 32'hF);
      end
      cyc();
    end

    // 4: DM backpressure, hold, accept with same-cycle regrant
    req = 0; rdy = 0;
    do_rst(1);
    req[1] = 1; addr[1] = 8;
    @(negedge CLK); chk("t4_dgnt0", dm_gnt, 1);
    cyc(); addr[1] = 2;
    for (int j = 0; j < 3; j++) begin
      @(negedge CLK);
      chk("t4_dvld", dm_rsp_valid, 1); chk("t4_ddat", dm_rsp_data, 32'hF);
      chk("t4_dgnt", dm_gnt, 0);
      cyc();
    end
    rdy[1] = 1;
    @(negedge CLK);
    chk("t4_acc_vld", dm_rsp_valid, 1); chk("t4_acc_dat", dm_rsp_data, 32'hF);
    chk("t4_regnt", dm_gnt, 1); chk("t4_maddr", mem_addr, 2);
    cyc(); req[1] = 0;
    @(negedge CLK);
    chk("t4_new_vld", dm_rsp_valid, 1); chk("t4_new_dat", dm_rsp_data, 32'h3);
    cyc();
    @(negedge CLK); chk("t4_end_vld", dm_rsp_valid, 0);

    // 5: read granted just before reset is dropped; IF wins next conflict
    cyc(); req = 0; rdy = 2'b11;
    do_rst(1);
    req[0] = 1; addr[0] = 1;
    @(negedge CLK); chk("t5_ignt", if_gnt, 1);
    cyc(); req = 2'b11; addr[0] = 7; addr[1] = 8;
    do_rst(2);
    @(negedge CLK);
    chk("t5_ivld", if_rsp_valid, 0); chk("t5_dvld", dm_rsp_valid, 0);
    chk("t5_ignt2", if_gnt, 1); chk("t5_dgnt2", dm_gnt, 0);
    cyc(); req = 0;
    @(negedge CLK);
    chk("t5_ivld2", if_rsp_valid, 1); chk("t5_idat", if_rsp_data, 32'h7);

    // 6: random traffic against the reference model
    cyc();
    do_rst(1);
    mv = '0; mlast = 1'b1; md[0] = '0; md[1] = '0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge CLK);
      el   = ~mv | rdy;
      cand = req & el;
      eg   = (&cand) ? (mlast ? 2'b01 : 2'b10) : cand;
      chk("r_gnt", {30'd0, dm_gnt, if_gnt}, {30'd0, eg});
      chk("r_vld", {30'd0, dm_rsp_valid, if_rsp_valid}, {30'd0, mv});
      if (mv[0]) chk("r_idat", if_rsp_data, md[0]);
      if (mv[1]) chk("r_ddat", dm_rsp_data, md[1]);
      chk("r_inv_if", u_dut.g_port[0].u_port.inflight & u_dut.g_port[0].u_port.hold, 0);
      chk("r_inv_dm", u_dut.g_port[1].u_port.inflight & u_dut.g_port[1].u_port.hold, 0);
      for (int p = 0; p < 2; p++) begin
        if (eg[p]) begin
          mv[p] = 1'b1; md[p] = rom[addr[p]];
        end else if (rdy[p]) begin
          mv[p] = 1'b0;
        end
      end
      if (|eg) mlast = eg[1];
      cyc();
      for (int p = 0; p < 2; p++)
        if (!req[p] || eg[p]) begin
          req[p]  = 1'($urandom_range(0, 1));
          addr[p] = 4'($urandom_range(0, 15));
        end
      rdy = 2'($urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
